speicher_schnittstelle: RTL and testbench

Single-port memory bus master between the processor control FSM and external memory, serving instruction fetch, data load and data store. It accepts the level-held request strobes from the control FSM and runs a request/ready handshake on the memory port. It returns a one-cycle completion pulse (BefehlGeladen, DatenGeladen, DatenGespeichert) and holds fetched data in registers. A watchdog guarantees completion even if memory never answers.

---
 rtl/speicher_schnittstelle.sv | 122 ++++++++++++
 tb/tb_speicher_schnittstelle.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_schnittstelle.sv
// Single-port memory bus master serving instruction fetch, data load and data store.
// Level-held requests in, one-cycle done pulses out, watchdog bounds every access.
module speicher_schnittstelle #(
  parameter int ADRESS_BREITE = 32,
  parameter int DATEN_BREITE  = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     LoadBefehlSignal,
  input  logic                     LoadDatenSignal,
  input  logic                     StoreDatenSignal,
  input  logic [ADRESS_BREITE-1:0] PC,
  input  logic [ADRESS_BREITE-1:0] Adresse,
  input  logic [DATEN_BREITE-1:0]  SchreibDaten,
  output logic [DATEN_BREITE-1:0]  Befehl,
  output logic [DATEN_BREITE-1:0]  LeseDaten,
  output logic                     BefehlGeladen,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic                     Zeitueberschreitung,
  output logic [ADRESS_BREITE-1:0] MemAdresse,
  output logic [DATEN_BREITE-1:0]  MemSchreibDaten,
  output logic                     MemLesen,
  output logic                     MemSchreiben,
  input  logic [DATEN_BREITE-1:0]  MemLeseDaten,
  input  logic                     MemBereit
);

  localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            WD_AN     = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LETZT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {IDLE, LESEN_B, LESEN_D, SCHREIBEN, FERTIG} zustand_t;

  zustand_t r_zustand, w_naechster;
  logic     w_zugriff, w_ablauf;
  logic [CW-1:0] r_cnt;

  logic [DATEN_BREITE-1:0]  r_befehl, r_lese, r_wdat;
  logic [ADRESS_BREITE-1:0] r_adr;
  logic r_bgel, r_dgel, r_dgesp, r_timeout, r_lesen, r_schreiben;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_zustand <= IDLE;
    else       r_zustand <= w_naechster;
  end

  // The access state itself records the access kind, so no separate kind register.
  always_comb begin
    w_naechster = r_zustand;
    w_ablauf    = 1'b0;
    w_zugriff   = 1'b0;
    case (r_zustand)
      IDLE: begin
        if (StoreDatenSignal)      w_naechster = SCHREIBEN;
        else if (LoadDatenSignal)  w_naechster = LESEN_D;
        else if (LoadBefehlSignal) w_naechster = LESEN_B;
      end
      LESEN_B, LESEN_D, SCHREIBEN: begin
        w_zugriff = 1'b1;
        if (MemBereit) begin
          w_naechster = FERTIG;
        end else if (WD_AN && (r_cnt == CNT_LETZT)) begin
          w_ablauf    = 1'b1;
          w_naechster = FERTIG;
        end
      end
      FERTIG:  w_naechster = IDLE;
      default: w_naechster = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt       <= '0;
      r_adr       <= '0;
      r_wdat      <= '0;
      r_befehl    <= '0;
      r_lese      <= '0;
      r_bgel      <= 1'b0;
      r_dgel      <= 1'b0;
      r_dgesp     <= 1'b0;
      r_timeout   <= 1'b0;
      r_lesen     <= 1'b0;
      r_schreiben <= 1'b0;
    end else begin
      r_lesen     <= (w_naechster == LESEN_B) || (w_naechster == LESEN_D);
      r_schreiben <= (w_naechster == SCHREIBEN);
      r_bgel      <= (w_naechster == FERTIG) && (r_zustand == LESEN_B);
      r_dgel      <= (w_naechster == FERTIG) && (r_zustand == LESEN_D);
      r_dgesp     <= (w_naechster == FERTIG) && (r_zustand == SCHREIBEN);

      if (r_zustand == IDLE && w_naechster != IDLE) begin
        r_adr  <= (w_naechster == LESEN_B) ? PC : Adresse;
        r_wdat <= SchreibDaten;
      end

      if (w_zugriff && !MemBereit) r_cnt <= r_cnt + 1'b1;
      else if (r_zustand == FERTIG) r_cnt <= '0;

      // A timed-out read leaves a defined zero rather than stale bus data.
      if (w_zugriff && (MemBereit || w_ablauf)) begin
        if (r_zustand == LESEN_B) r_befehl <= MemBereit ? MemLeseDaten : '0;
        if (r_zustand == LESEN_D) r_lese   <= MemBereit ? MemLeseDaten : '0;
      end
      if (w_ablauf) r_timeout <= 1'b1;
    end
  end

  assign Befehl              = r_befehl;
  assign LeseDaten           = r_lese;
  assign BefehlGeladen       = r_bgel;
  assign DatenGeladen        = r_dgel;
  assign DatenGespeichert    = r_dgesp;
  assign Zeitueberschreitung = r_timeout;
  assign MemAdresse          = r_adr;
  assign MemSchreibDaten     = r_wdat;
  assign MemLesen            = r_lesen;
  assign MemSchreiben        = r_schreiben;

endmodule

// File: tb/tb_speicher_schnittstelle.sv
// Scoreboard bench: stimulus queues expected accesses, a memory responder and a
// done monitor consume them independently.
module tb_speicher_schnittstelle;
  localparam int AB = 32;
  localparam int DB = 32;
  localparam int TO = 4;

  logic Clock = 1'b0, Reset = 1'b1;
  logic LoadBefehlSignal = 0, LoadDatenSignal = 0, StoreDatenSignal = 0;
  logic [AB-1:0] PC = '0, Adresse = '0;
  logic [DB-1:0] SchreibDaten = '0;
  logic [DB-1:0] Befehl, LeseDaten, MemSchreibDaten;
  logic [DB-1:0] MemLeseDaten = '0;
  logic [AB-1:0] MemAdresse;
  logic BefehlGeladen, DatenGeladen, DatenGespeichert, Zeitueberschreitung;
  logic MemLesen, MemSchreiben;
  logic MemBereit = 1'b0;

  speicher_schnittstelle #(.ADRESS_BREITE(AB), .DATEN_BREITE(DB), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .LoadBefehlSignal(LoadBefehlSignal), .LoadDatenSignal(LoadDatenSignal),
    .StoreDatenSignal(StoreDatenSignal), .PC(PC), .Adresse(Adresse),
    .SchreibDaten(SchreibDaten), .Befehl(Befehl), .LeseDaten(LeseDaten),
    .BefehlGeladen(BefehlGeladen), .DatenGeladen(DatenGeladen),
    .DatenGespeichert(DatenGespeichert), .Zeitueberschreitung(Zeitueberschreitung),
    .MemAdresse(MemAdresse), .MemSchreibDaten(MemSchreibDaten),
    .MemLesen(MemLesen), .MemSchreiben(MemSchreiben),
    .MemLeseDaten(MemLeseDaten), .MemBereit(MemBereit)
  );

  always #5 Clock = ~Clock;

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;
    bit          to;
  } acc_t;

  acc_t mem_q[$];
  acc_t done_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_b = '0, exp_d = '0;
  bit          exp_to = 1'b0;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Memory responder: checks each bus access against the expected queue and
  // answers after the access's planned number of wait cycles.
  bit   in_acc = 0;
  int   cyc = 0;
  acc_t cur;
  logic [31:0] a0, d0;

  always @(negedge Clock) begin
    if (Reset) begin
      in_acc    = 0;
      MemBereit = 1'b0;
    end else if (MemLesen || MemSchreiben) begin
      if (!in_acc) begin
        in_acc = 1;
        cyc    = 0;
        a0     = MemAdresse;
        d0     = MemSchreibDaten;
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access: got addr %0h expected no access", MemAdresse);
          cur = '{kind: 0, addr: 0, wdata: 0, rdata: 0, w: 0, to: 0};
        end else begin
          cur = mem_q.pop_front();
          chk("acc_addr", MemAdresse, cur.addr);
          chk("acc_wdata", MemSchreibDaten, cur.wdata);
        end
      end else begin
        chk("addr_stable", MemAdresse, a0);
        chk("wdata_stable", MemSchreibDaten, d0);
      end
      chk("strobe_kind", {MemLesen, MemSchreiben}, (cur.kind == 2) ? 2'b01 : 2'b10);
      MemBereit    = (cyc == cur.w);
      MemLeseDaten = (cyc == cur.w) ? cur.rdata : $urandom;
      cyc++;
    end else begin
      if (in_acc) begin
        chk("strobe_len", cyc, cur.to ? TO : cur.w + 1);
        in_acc = 0;
      end
      MemBereit    = $urandom_range(0, 1);
      MemLeseDaten = $urandom;
    end
  end

  // Done monitor: pops one expected completion per pulse and updates the model.
  always @(negedge Clock) begin
    int   n, kg;
    acc_t a;
    if (!Reset) begin
      n = int'(BefehlGeladen) + int'(DatenGeladen) + int'(DatenGespeichert);
      if (n != 0) begin
        chk("one_pulse", n, 1);
        chk("no_strobe_in_fertig", {MemLesen, MemSchreiben}, 2'b00);
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got pulse %0d expected none", n);
        end else begin
          a  = done_q.pop_front();
          kg = BefehlGeladen ? 0 : (DatenGeladen ? 1 : 2);
          chk("done_kind", kg, a.kind);
          if (a.kind == 0) exp_b = a.to ? 32'h0 : a.rdata;
          if (a.kind == 1) exp_d = a.to ? 32'h0 : a.rdata;
          if (a.to) exp_to = 1'b1;
          chk("befehl", Befehl, exp_b);
          chk("lesedaten", LeseDaten, exp_d);
          chk("timeout_flag", Zeitueberschreitung, exp_to);
        end
      end
    end
  end

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (BefehlGeladen || DatenGeladen || DatenGespeichert) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done pulse expected one within 40 cycles");
    end
  endtask

  task automatic drop(input int k);
    if (k == 0) LoadBefehlSignal = 1'b0;
    if (k == 1) LoadDatenSignal  = 1'b0;
    if (k == 2) StoreDatenSignal = 1'b0;
  endtask

  // Raise the requested strobes together; they are served store > load > fetch.
  task automatic run(input bit lb, input bit ld, input bit st,
                     input logic [31:0] pc, input logic [31:0] adr, input logic [31:0] wd,
                     input int w_first, input logic [31:0] rd_first, input bit slow);
    int   kinds[$];
    acc_t a;
    if (st) kinds.push_back(2);
    if (ld) kinds.push_back(1);
    if (lb) kinds.push_back(0);
    for (int i = 0; i < kinds.size(); i++) begin
      a.kind  = kinds[i];
      a.addr  = (kinds[i] == 0) ? pc : adr;
      a.wdata = wd;
      a.w     = (i == 0) ? w_first : $urandom_range(0, 2);
      a.rdata = (i == 0) ? rd_first : $urandom;
      a.to    = (a.w >= TO);
      mem_q.push_back(a);
      done_q.push_back(a);
    end
    PC = pc; Adresse = adr; SchreibDaten = wd;
    LoadBefehlSignal = lb; LoadDatenSignal = ld; StoreDatenSignal = st;
    for (int i = 0; i < kinds.size(); i++) begin
      wait_done();
      if (slow) @(negedge Clock);
      drop(kinds[i]);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {Befehl, LeseDaten, MemAdresse, MemSchreibDaten, BefehlGeladen, DatenGeladen,
             DatenGespeichert, Zeitueberschreitung, MemLesen, MemSchreiben}, '0);
  endtask

  initial begin
    bit   seen;
    acc_t a;
    repeat (2) @(negedge Clock);
    chk_all_zero("reset_state");
    Reset = 1'b0;
    @(negedge Clock);

    // zero-wait fetch
    run(1, 0, 0, 32'h100, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0);
    // store with three wait cycles
    run(0, 0, 1, 32'h0, 32'h2000, 32'h12345678, 3, 32'h0, 0);
    // load and fetch together: load first
    run(1, 1, 0, 32'h400, 32'h3000, 32'h0, 1, 32'hCAFEF00D, 0);
    // load that never gets an answer
    run(0, 1, 0, 32'h0, 32'h4000, 32'h0, 1000, 32'h55AA55AA, 0);
    // requester releases one cycle late
    run(1, 0, 0, 32'h500, 32'h0, 32'h0, 2, 32'h0BADCAFE, 1);
    repeat (3) @(negedge Clock);

    for (int i = 0; i < 40; i++) begin
      int m;
      m = $urandom_range(1, 7);
      run(m[0], m[1], m[2], $urandom, $urandom, $urandom, $urandom_range(0, 6), $urandom,
          bit'($urandom_range(0, 1)));
    end

    // reset in the middle of a fetch
    a = '{kind: 0, addr: 32'h600, wdata: 32'h0, rdata: 32'h11111111, w: 5, to: 1};
    mem_q.push_back(a);
    done_q.push_back(a);
    PC = 32'h600; SchreibDaten = 32'h0; LoadBefehlSignal = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (MemLesen) begin seen = 1; break; end
    end
    chk("reset_mid_strobe_seen", seen, 1'b1);
    #2 Reset = 1'b1;
    #1 chk_all_zero("reset_mid_outputs");
    LoadBefehlSignal = 1'b0;
    done_q.delete();
    mem_q.delete();
    exp_b = '0; exp_d = '0; exp_to = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    run(1, 0, 0, 32'h700, 32'h0, 32'h0, 1, 32'h76543210, 0);

    repeat (5) @(negedge Clock);
    chk("queues_empty", mem_q.size() + done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
